cpu_ctrl_seq: RTL and testbench

CPU_CTRL_SEQ -- requirements
Module: cpu_ctrl_seq

---
 rtl/cpu_ctrl_seq.sv | 149 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXEC/WB per instruction,
// with instruction-count halting, branch/jump PC update and sticky illegal-opcode flag.
module cpu_ctrl_seq #(
  parameter logic [31:0] ENTRY_PC = 32'h28,
  parameter logic [2:0]  OP_ADD   = 3'b010,
  parameter logic [2:0]  OP_SUB   = 3'b110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  ins_limit,
  input  logic [31:0] ins,
  input  logic [31:0] imm,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        reg_write,
  output logic        alu_src,
  output logic [2:0]  op,
  output logic        mem_write,
  output logic [7:0]  retired,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t      r_state;
  logic        r_dec_rw;
  logic        r_dec_mw;
  logic        r_dec_sb;
  logic        r_dec_uj;
  logic        r_take;
  logic [31:0] r_imm;

  logic        w_alu_src;
  logic [2:0]  w_op;
  logic        w_rw;
  logic        w_mw;
  logic        w_sb;
  logic        w_uj;
  logic        w_ill;
  logic [7:0]  w_ret_inc;
  logic        w_limit_hit;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_tgt;
  logic        w_unused;

  // Only the opcode field steers control; the remaining bits belong to the datapath.
  assign w_unused = ^ins[31:7];

  always_comb begin
    w_alu_src = 1'b0;
    w_op      = OP_ADD;
    w_rw      = 1'b0;
    w_mw      = 1'b0;
    w_sb      = 1'b0;
    w_uj      = 1'b0;
    w_ill     = 1'b0;
    case (ins[6:0])
      7'h33:        w_rw = 1'b1;
      7'h03, 7'h13: begin w_alu_src = 1'b1; w_rw = 1'b1; end
      7'h23:        begin w_alu_src = 1'b1; w_mw = 1'b1; end
      7'h63:        begin w_op = OP_SUB; w_sb = 1'b1; end
      7'h6F:        begin w_alu_src = 1'b1; w_uj = 1'b1; end
      default:      w_ill = 1'b1;
    endcase
  end

  assign w_ret_inc   = retired + 8'd1;
  assign w_limit_hit = (ins_limit != 8'd0) && (w_ret_inc == ins_limit);
  assign w_pc_seq    = pc + 32'd4;
  assign w_pc_tgt    = pc + r_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      pc        <= ENTRY_PC;
      retired   <= 8'd0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      alu_src   <= 1'b0;
      op        <= OP_ADD;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      r_dec_rw  <= 1'b0;
      r_dec_mw  <= 1'b0;
      r_dec_sb  <= 1'b0;
      r_dec_uj  <= 1'b0;
      r_take    <= 1'b0;
      r_imm     <= 32'd0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_state <= FETCH;
            pc      <= ENTRY_PC;
            retired <= 8'd0;
            illegal <= 1'b0;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_state  <= EXEC;
          r_dec_rw <= w_rw;
          r_dec_mw <= w_mw;
          r_dec_sb <= w_sb;
          r_dec_uj <= w_uj;
          r_imm    <= imm;
          // An unknown opcode leaves the ALU controls at their last decoded values.
          if (w_ill) begin
            illegal <= 1'b1;
          end else begin
            alu_src <= w_alu_src;
            op      <= w_op;
          end
        end
        EXEC: begin
          r_state   <= WB;
          r_take    <= r_dec_sb & zero;
          reg_write <= r_dec_rw;
          mem_write <= r_dec_mw;
        end
        WB: begin
          reg_write <= 1'b0;
          mem_write <= 1'b0;
          retired   <= w_ret_inc;
          pc        <= (r_take || r_dec_uj) ? w_pc_tgt : w_pc_seq;
          if (illegal || w_limit_hit) begin
            r_state <= HALT;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end else begin
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: the driver pushes per-instruction expectations
// from an abstract program model; a monitor pops them at each retirement.
module tb_cpu_ctrl_seq;
  localparam logic [31:0] ENTRY = 32'h28;
  localparam logic [2:0]  OPA   = 3'b010;
  localparam logic [2:0]  OPS   = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ins_limit = 8'd0;
  logic [31:0] ins = 32'd0;
  logic [31:0] imm = 32'd0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic        reg_write, alu_src, mem_write, busy, halted, illegal;
  logic [2:0]  op;
  logic [7:0]  retired;

  cpu_ctrl_seq #(.ENTRY_PC(ENTRY), .OP_ADD(OPA), .OP_SUB(OPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins_limit(ins_limit), .ins(ins),
    .imm(imm), .zero(zero), .pc(pc), .reg_write(reg_write), .alu_src(alu_src),
    .op(op), .mem_write(mem_write), .retired(retired), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc_start;
    logic [31:0] pc_next;
    logic [7:0]  ret;
    logic [3:0]  rw_mask;
    logic [3:0]  mw_mask;
    logic        as;
    logic [2:0]  op;
    logic        ill;
    logic        halt;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic        zero;
  } instr_t;

  exp_t   sb_q[$];
  instr_t prog_q[$];

  // Architectural view kept by the model: last decoded ALU controls survive runs, not resets.
  logic       m_as = 1'b0;
  logic [2:0] m_op = OPA;

  // ---------------- monitor ----------------
  initial begin
    logic        prev_busy;
    logic [7:0]  prev_ret;
    int          win;
    logic [3:0]  rw_m, mw_m;
    logic [31:0] win_pc;
    logic        last_as;
    logic [2:0]  last_op;
    exp_t        e;
    prev_busy = 1'b0; prev_ret = 8'd0; win = 0; rw_m = 4'd0; mw_m = 4'd0;
    win_pc = 32'd0; last_as = 1'b0; last_op = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0; prev_ret = retired; win = 0; rw_m = 4'd0; mw_m = 4'd0;
      end else begin
        if (prev_busy && (retired !== prev_ret)) begin
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL retire_unexpected: got retired=%h with no expectation queued", retired);
          end else begin
            e = sb_q.pop_front();
            chk("pc_during_instr", win_pc, e.pc_start);
            chk("instr_cycles", win, 4);
            chk("reg_write_slots", {28'd0, rw_m}, {28'd0, e.rw_mask});
            chk("mem_write_slots", {28'd0, mw_m}, {28'd0, e.mw_mask});
            chk("alu_src", {31'd0, last_as}, {31'd0, e.as});
            chk("op", {29'd0, last_op}, {29'd0, e.op});
            chk("pc_next", pc, e.pc_next);
            chk("retired", {24'd0, retired}, {24'd0, e.ret});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("halted", {31'd0, halted}, {31'd0, e.halt});
          end
          win = 0; rw_m = 4'd0; mw_m = 4'd0;
        end
        if (busy) begin
          if (win == 0) win_pc = pc;
          if (win < 4) begin
            rw_m[win] = reg_write;
            mw_m[win] = mem_write;
          end else if (reg_write || mem_write) begin
            rw_m = 4'hF; mw_m = 4'hF;
          end
          win++;
          last_as = alu_src;
          last_op = op;
        end else if (reg_write || mem_write) begin
          checks++; failures++;
          $display("FAIL stray_strobe: reg_write=%b mem_write=%b while not busy", reg_write, mem_write);
        end
        prev_busy = busy;
        prev_ret  = retired;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_ins(input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], opc};
  endfunction

  task automatic push_instr(input logic [6:0] opc, input logic [31:0] im, input logic z);
    instr_t t;
    t.ins = mk_ins(opc); t.imm = im; t.zero = z;
    prog_q.push_back(t);
  endtask

  task automatic gen_prog(input int n, input bit end_illegal, input bit allow_ill);
    logic [6:0] legal[6] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F};
    logic [6:0] bad[6]   = '{7'h7F, 7'h00, 7'h37, 7'h17, 7'h67, 7'h73};
    logic [31:0] im;
    logic [31:0] r;
    int v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 63) - 32) * 4;
      im = v;
      if ($urandom_range(0, 7) == 0) im = $urandom();
      if (allow_ill && $urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 5);
        push_instr(bad[r], im, 1'($urandom_range(0, 1)));
      end else begin
        r = $urandom_range(0, 5);
        push_instr(legal[r], im, 1'($urandom_range(0, 1)));
      end
    end
    if (end_illegal) begin
      r = $urandom_range(0, 5);
      push_instr(bad[r], 32'd0, 1'b0);
    end
  endtask

  // Runs prog_q from a start pulse, pushing the model's expectation for each instruction.
  task automatic run_prog(input logic [7:0] lim);
    logic [31:0] pcm;
    logic [7:0]  retm;
    logic        illm, halt, rw, mw, tgt, ill;
    instr_t      t;
    exp_t        e;
    int          k, sp;
    bit          inj;
    pcm = ENTRY; retm = 8'd0; illm = 1'b0; halt = 1'b0; k = 0;
    @(negedge clk);
    ins_limit = lim;
    while (!halt && prog_q.size() != 0) begin
      t = prog_q.pop_front();
      ins = t.ins; imm = t.imm; zero = t.zero;
      rw = 1'b0; mw = 1'b0; tgt = 1'b0; ill = 1'b0;
      case (t.ins[6:0])
        7'h33:        begin rw = 1'b1; m_as = 1'b0; m_op = OPA; end
        7'h03, 7'h13: begin rw = 1'b1; m_as = 1'b1; m_op = OPA; end
        7'h23:        begin mw = 1'b1; m_as = 1'b1; m_op = OPA; end
        7'h63:        begin tgt = t.zero; m_as = 1'b0; m_op = OPS; end
        7'h6F:        begin tgt = 1'b1; m_as = 1'b1; m_op = OPA; end
        default:      ill = 1'b1;
      endcase
      e.pc_start = pcm;
      pcm  = tgt ? pcm + t.imm : pcm + 32'd4;
      retm = retm + 8'd1;
      illm = illm | ill;
      halt = ill || (lim != 8'd0 && retm == lim);
      e.pc_next = pcm; e.ret = retm;
      e.rw_mask = rw ? 4'b1000 : 4'b0000;
      e.mw_mask = mw ? 4'b1000 : 4'b0000;
      e.as = m_as; e.op = m_op; e.ill = illm; e.halt = halt;
      sb_q.push_back(e);
      if (k == 0) start = 1'b1;
      sp  = $urandom_range(0, 2);
      inj = 1'($urandom_range(0, 1));
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) begin
          start = 1'b0;
          chk("start_pc", pc, ENTRY);
          chk("start_retired", {24'd0, retired}, 32'd0);
          chk("start_illegal", {31'd0, illegal}, 32'd0);
          chk("start_busy", {31'd0, busy}, 32'd1);
        end else begin
          start = (inj && c == sp) ? 1'b1 : 1'b0;
        end
      end
      k++;
    end
    start = 1'b0;
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("end_halted", {31'd0, halted}, 32'd1);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_pc", pc, pcm);
    chk("end_retired", {24'd0, retired}, {24'd0, retm});
    prog_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, ENTRY);
    chk("rst_retired", {24'd0, retired}, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_alu_src", {31'd0, alu_src}, 32'd0);
    chk("rst_op", {29'd0, op}, {29'd0, OPA});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_halted", {31'd0, halted}, 32'd0);

    // three R-type with limit 3
    repeat (3) push_instr(7'h33, 32'd0, 1'b0);
    run_prog(8'd3);
    // taken branch, untaken branch, store
    push_instr(7'h63, 32'h10, 1'b1);
    run_prog(8'd1);
    push_instr(7'h63, 32'h10, 1'b0);
    run_prog(8'd1);
    push_instr(7'h23, 32'h8, 1'b0);
    run_prog(8'd1);
    // illegal opcode halts; the next run's start checks the flag clears
    push_instr(7'h7F, 32'h0, 1'b0);
    run_prog(8'd0);
    push_instr(7'h6F, 32'hFFFF_FFD8, 1'b0);
    run_prog(8'd1);

    // reset during EXEC of the second instruction (an I-type)
    @(negedge clk);
    ins_limit = 8'd0; ins = mk_ins(7'h33); imm = 32'd0; zero = 1'b0; start = 1'b1;
    e.pc_start = ENTRY; e.pc_next = ENTRY + 32'd4; e.ret = 8'd1;
    e.rw_mask = 4'b1000; e.mw_mask = 4'b0000; e.as = 1'b0; e.op = OPA;
    e.ill = 1'b0; e.halt = 1'b0;
    sb_q.push_back(e);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    ins = mk_ins(7'h13); imm = 32'h40;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", pc, ENTRY);
    chk("midrst_retired", {24'd0, retired}, 32'd0);
    chk("midrst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("midrst_alu_src", {31'd0, alu_src}, 32'd0);
    chk("midrst_op", {29'd0, op}, {29'd0, OPA});
    m_as = 1'b0; m_op = OPA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_reg_write", {31'd0, reg_write}, 32'd0);
    end
    chk("midrst_sb_empty", sb_q.size(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_pc", pc, ENTRY);

    // randomized programs
    for (int r = 0; r < 6; r++) begin
      logic [7:0] lim;
      lim = (r % 3 == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      if (lim == 8'd0) gen_prog(12, 1'b1, 1'b0);
      else             gen_prog(int'(lim), 1'b0, 1'b1);
      run_prog(lim);
    end
    // long unlimited run so retired wraps past 8'hFF
    gen_prog(260, 1'b1, 1'b0);
    run_prog(8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
